fetch_decode: RTL and testbench

FETCH_DECODE -- requirements
Module: fetch_decode

---
 rtl/fetch_pkg.sv | 44 ++++
 rtl/fetch_opdecode.sv | 35 +++
 rtl/fetch_decode.sv | 184 ++++++++++++++++++
 tb/tb_fetch_decode.sv | 231 +++++++++++++++++++++++
 4 files changed

// File: rtl/fetch_pkg.sv
// Shared constants and types for the instruction fetch/decode controller.
package fetch_pkg;

  localparam int unsigned OpcodeW = 6;
  localparam int unsigned Param1W = 6;
  localparam int unsigned Param2W = 6;
  localparam int unsigned WordW   = OpcodeW + Param1W + Param2W;
  localparam int unsigned NumExec = 5;

  // Highest register index an executor instruction may name.
  localparam logic [Param1W-1:0] MaxRegIdx = 6'd4;

  localparam logic [OpcodeW-1:0] OpNop   = 6'h00;
  localparam logic [OpcodeW-1:0] OpLoad  = 6'h01;
  localparam logic [OpcodeW-1:0] OpStore = 6'h02;
  localparam logic [OpcodeW-1:0] OpMove  = 6'h03;
  localparam logic [OpcodeW-1:0] OpAdd   = 6'h04;
  localparam logic [OpcodeW-1:0] OpSub   = 6'h05;
  localparam logic [OpcodeW-1:0] OpHalt  = 6'h3F;

  typedef enum logic [3:0] {
    StIdle,
    StF1,
    StF2,
    StF3,
    StF4,
    StDec,
    StExec,
    StClr,
    StHalt
  } state_e;

  // Fetch datapath strobes, one per bus/memory control line.
  typedef struct packed {
    logic pc_out_en;
    logic mar_in;
    logic en;
    logic rw;
    logic mdr_to_bus;
    logic ir_in;
    logic pc_inc;
  } fetch_ctrl_t;

endpackage

// File: rtl/fetch_opdecode.sv
// Combinational opcode classifier: one-hot executor start plus nop/halt/illegal flags.
module fetch_opdecode
  import fetch_pkg::*;
(
  input  logic [OpcodeW-1:0] opcode_i,
  input  logic [Param1W-1:0] param1_i,
  input  logic [Param2W-1:0] param2_i,
  output logic [NumExec-1:0] start_o,
  output logic               nop_o,
  output logic               halt_o,
  output logic               illegal_o
);

  logic params_ok;

  // Classify the latched instruction; executor ops with out-of-range registers are illegal.
  always_comb begin
    start_o   = '0;
    nop_o     = 1'b0;
    halt_o    = 1'b0;
    illegal_o = 1'b0;
    params_ok = (param1_i <= MaxRegIdx) && (param2_i <= MaxRegIdx);
    case (opcode_i)
      OpNop:   nop_o = 1'b1;
      OpHalt:  halt_o = 1'b1;
      OpLoad:  if (params_ok) start_o = 5'b00001; else illegal_o = 1'b1;
      OpStore: if (params_ok) start_o = 5'b00010; else illegal_o = 1'b1;
      OpMove:  if (params_ok) start_o = 5'b00100; else illegal_o = 1'b1;
      OpAdd:   if (params_ok) start_o = 5'b01000; else illegal_o = 1'b1;
      OpSub:   if (params_ok) start_o = 5'b10000; else illegal_o = 1'b1;
      default: illegal_o = 1'b1;
    endcase
  end

endmodule

// File: rtl/fetch_decode.sv
// Instruction fetch/decode sequencer: four fetch steps, decode, then hands the instruction to
// one executor FSM and waits for its done pulse. Optional EXEC watchdog is enabled by
// defining FETCH_EXEC_TIMEOUT_EN (adds the sticky timeout output).
module fetch_decode
  import fetch_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic               run,
  input  logic [WordW-1:0]   mem_word,
  input  logic               exec_done,
  output logic               PCOutEn,
  output logic               MARin,
  output logic               EN,
  output logic               RW,
  output logic               MDR_tobusin,
  output logic               IRin,
  output logic               PCinc,
  output logic [NumExec-1:0] exec_start,
  output logic [Param1W-1:0] parameter1,
  output logic [Param2W-1:0] parameter2,
  output logic               donefetch,
  output logic               halted,
  output logic               illegal
`ifdef FETCH_EXEC_TIMEOUT_EN
  ,
  output logic               timeout
`endif
);

  state_e               state_q, state_d;
  logic [OpcodeW-1:0]   opcode_q, opcode_d;
  logic [Param1W-1:0]   param1_q, param1_d;
  logic [Param2W-1:0]   param2_q, param2_d;
  fetch_ctrl_t          ctrl_q, ctrl_d;
  logic [NumExec-1:0]   start_q, start_d;
  logic                 donefetch_q, donefetch_d;
  logic                 halted_q, halted_d;
  logic                 illegal_q, illegal_d;
`ifdef FETCH_EXEC_TIMEOUT_EN
  logic [7:0]           cnt_q, cnt_d;
  logic                 timeout_q, timeout_d;
`endif

  logic [NumExec-1:0]   dec_start;
  logic                 dec_nop;
  logic                 dec_halt;
  logic                 dec_illegal;

  fetch_opdecode u_opdecode (
    .opcode_i  (opcode_q),
    .param1_i  (param1_q),
    .param2_i  (param2_q),
    .start_o   (dec_start),
    .nop_o     (dec_nop),
    .halt_o    (dec_halt),
    .illegal_o (dec_illegal)
  );

  // Next state and next outputs; outputs are derived from state_d so they are registered
  // and line up with the state they belong to.
  always_comb begin
    state_d     = state_q;
    opcode_d    = opcode_q;
    param1_d    = param1_q;
    param2_d    = param2_q;
    halted_d    = halted_q;
    illegal_d   = illegal_q;
`ifdef FETCH_EXEC_TIMEOUT_EN
    cnt_d       = cnt_q;
    timeout_d   = timeout_q;
`endif

    case (state_q)
      StIdle: if (run) state_d = StF1;
      StF1:   state_d = StF2;
      StF2:   state_d = StF3;
      StF3: begin
        // Word is on the bus during F3; latch it as we move to F4.
        state_d  = StF4;
        opcode_d = mem_word[WordW-1 -: OpcodeW];
        param1_d = mem_word[Param1W+Param2W-1 -: Param1W];
        param2_d = mem_word[Param2W-1:0];
      end
      StF4:   state_d = StDec;
      StDec: begin
        if (dec_nop) begin
          state_d = StF1;
        end else if (dec_halt) begin
          state_d  = StHalt;
          halted_d = 1'b1;
        end else if (dec_illegal) begin
          state_d   = StHalt;
          illegal_d = 1'b1;
        end else begin
          state_d = StExec;
`ifdef FETCH_EXEC_TIMEOUT_EN
          cnt_d   = '0;
`endif
        end
      end
      StExec: begin
        if (exec_done) begin
          state_d = StClr;
`ifdef FETCH_EXEC_TIMEOUT_EN
        end else if (cnt_q == 8'd254) begin
          // Counter reaches 255 on this edge without a done: give up on the executor.
          state_d   = StClr;
          timeout_d = 1'b1;
`endif
        end
`ifdef FETCH_EXEC_TIMEOUT_EN
        cnt_d = cnt_q + 8'd1;
`endif
      end
      StClr:   state_d = run ? StF1 : StIdle;
      StHalt:  state_d = StHalt;
      default: state_d = StIdle;
    endcase

    ctrl_d            = '0;
    ctrl_d.pc_out_en  = (state_d == StF1);
    ctrl_d.mar_in     = (state_d == StF1);
    ctrl_d.en         = (state_d == StF2);
    ctrl_d.rw         = (state_d == StF2);
    ctrl_d.mdr_to_bus = (state_d == StF3);
    ctrl_d.ir_in      = (state_d == StF4);
    ctrl_d.pc_inc     = (state_d == StF4);
    // opcode_q is stable for the whole EXEC stay, so the decode can drive start directly.
    start_d           = (state_d == StExec) ? dec_start : '0;
    donefetch_d       = (state_d == StClr);
  end

  // State and registered outputs; synchronous reset wins over every transition.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StIdle;
      opcode_q    <= '0;
      param1_q    <= '0;
      param2_q    <= '0;
      ctrl_q      <= '0;
      start_q     <= '0;
      donefetch_q <= 1'b0;
      halted_q    <= 1'b0;
      illegal_q   <= 1'b0;
`ifdef FETCH_EXEC_TIMEOUT_EN
      cnt_q       <= '0;
      timeout_q   <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      opcode_q    <= opcode_d;
      param1_q    <= param1_d;
      param2_q    <= param2_d;
      ctrl_q      <= ctrl_d;
      start_q     <= start_d;
      donefetch_q <= donefetch_d;
      halted_q    <= halted_d;
      illegal_q   <= illegal_d;
`ifdef FETCH_EXEC_TIMEOUT_EN
      cnt_q       <= cnt_d;
      timeout_q   <= timeout_d;
`endif
    end
  end

  assign PCOutEn     = ctrl_q.pc_out_en;
  assign MARin       = ctrl_q.mar_in;
  assign EN          = ctrl_q.en;
  assign RW          = ctrl_q.rw;
  assign MDR_tobusin = ctrl_q.mdr_to_bus;
  assign IRin        = ctrl_q.ir_in;
  assign PCinc       = ctrl_q.pc_inc;
  assign exec_start  = start_q;
  assign parameter1  = param1_q;
  assign parameter2  = param2_q;
  assign donefetch   = donefetch_q;
  assign halted      = halted_q;
  assign illegal     = illegal_q;
`ifdef FETCH_EXEC_TIMEOUT_EN
  assign timeout     = timeout_q;
`endif

endmodule

// File: tb/tb_fetch_decode.sv
// Bench for fetch_decode: builds an expected per-cycle trace from instruction-level rules
// (fetch pattern, decode outcome, executor handshake) and replays it against the DUT.
module tb_fetch_decode;

  logic        clk;
  logic        rst;
  logic        run;
  logic [17:0] mem_word;
  logic        exec_done;
  logic        PCOutEn, MARin, EN, RW, MDR_tobusin, IRin, PCinc;
  logic [4:0]  exec_start;
  logic [5:0]  parameter1, parameter2;
  logic        donefetch, halted, illegal;
`ifdef FETCH_EXEC_TIMEOUT_EN
  logic        timeout;
`endif

  fetch_decode dut (
    .clk         (clk),
    .rst         (rst),
    .run         (run),
    .mem_word    (mem_word),
    .exec_done   (exec_done),
    .PCOutEn     (PCOutEn),
    .MARin       (MARin),
    .EN          (EN),
    .RW          (RW),
    .MDR_tobusin (MDR_tobusin),
    .IRin        (IRin),
    .PCinc       (PCinc),
    .exec_start  (exec_start),
    .parameter1  (parameter1),
    .parameter2  (parameter2),
    .donefetch   (donefetch),
    .halted      (halted),
    .illegal     (illegal)
`ifdef FETCH_EXEC_TIMEOUT_EN
    ,
    .timeout     (timeout)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // One cycle of the trace: inputs driven during the cycle and outputs expected in it.
  typedef struct packed {
    logic        rst;
    logic        run;
    logic [17:0] word;
    logic        done;
    logic [6:0]  ctrl;
    logic [4:0]  start;
    logic        dfetch;
    logic        hlt;
    logic        ill;
    logic        to;
    logic [5:0]  p1;
    logic [5:0]  p2;
  } cyc_t;

  localparam logic [6:0] CtrlF1   = 7'b1100000;
  localparam logic [6:0] CtrlF2   = 7'b0011000;
  localparam logic [6:0] CtrlF3   = 7'b0000100;
  localparam logic [6:0] CtrlF4   = 7'b0000011;
  localparam logic [6:0] CtrlNone = 7'b0000000;

  cyc_t       trace[$];
  logic [5:0] m_p1, m_p2;
  logic       m_hlt, m_ill, m_to;
  int         tests_run;
  int         tests_failed;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic rbit();
    return 1'($urandom_range(0, 1));
  endfunction

  function automatic logic spur();
    return ($urandom_range(0, 3) == 0);
  endfunction

  task automatic model_reset();
    m_p1 = '0; m_p2 = '0; m_hlt = 1'b0; m_ill = 1'b0; m_to = 1'b0;
  endtask

  task automatic add_cycle(input logic r, input logic rn, input logic [17:0] w, input logic dn,
                           input logic [6:0] c, input logic [4:0] s, input logic df);
    cyc_t e;
    e.rst = r; e.run = rn; e.word = w; e.done = dn;
    e.ctrl = c; e.start = s; e.dfetch = df;
    e.hlt = m_hlt; e.ill = m_ill; e.to = m_to; e.p1 = m_p1; e.p2 = m_p2;
    trace.push_back(e);
  endtask

  // Returns to the point where the next cycle is F1: idle with run low, then raise run.
  task automatic idle_then_run(input int n);
    for (int i = 0; i < n; i++) add_cycle(1'b0, 1'b0, 18'($urandom), spur(), CtrlNone, '0, 1'b0);
    add_cycle(1'b0, 1'b1, 18'($urandom), spur(), CtrlNone, '0, 1'b0);
  endtask

  // One instruction. d = EXEC cycles until done (0 = never, watchdog path);
  // abort = assert rst in the third EXEC cycle.
  task automatic gen_instr(input logic [17:0] w, input int d, input bit abort);
    logic [5:0] op, a, b;
    int         kind;   // 0 nop, 1 exec, 2 halt, 3 illegal
    logic [4:0] onehot;
    logic       r;
    op = w[17:12]; a = w[11:6]; b = w[5:0];
    onehot = '0;
    if (op == 6'h00) kind = 0;
    else if (op == 6'h3F) kind = 2;
    else if (op >= 6'h01 && op <= 6'h05) begin
      if (a > 6'd4 || b > 6'd4) kind = 3;
      else begin
        kind = 1;
        onehot = 5'd1 << (op - 6'd1);
      end
    end else kind = 3;

    add_cycle(1'b0, rbit(), 18'($urandom), spur(), CtrlF1, '0, 1'b0);
    add_cycle(1'b0, rbit(), 18'($urandom), spur(), CtrlF2, '0, 1'b0);
    add_cycle(1'b0, rbit(), w, spur(), CtrlF3, '0, 1'b0);
    m_p1 = a; m_p2 = b;
    add_cycle(1'b0, rbit(), 18'($urandom), spur(), CtrlF4, '0, 1'b0);
    add_cycle(1'b0, rbit(), 18'($urandom), spur(), CtrlNone, '0, 1'b0);

    if (kind == 1) begin
      int ncyc;
      ncyc = (d == 0) ? 255 : d;
      for (int k = 1; k <= ncyc; k++) begin
        if (abort && k == 3) begin
          add_cycle(1'b1, rbit(), 18'($urandom), rbit(), CtrlNone, onehot, 1'b0);
          model_reset();
          add_cycle(1'b0, 1'b1, 18'($urandom), 1'b0, CtrlNone, '0, 1'b0);
          return;
        end
        add_cycle(1'b0, rbit(), 18'($urandom), (d != 0) && (k == d), CtrlNone, onehot, 1'b0);
      end
      if (d == 0) m_to = 1'b1;
      r = rbit();
      add_cycle(1'b0, r, 18'($urandom), spur(), CtrlNone, '0, 1'b1);
      if (!r) idle_then_run($urandom_range(1, 3));
    end else if (kind >= 2) begin
      if (kind == 2) m_hlt = 1'b1; else m_ill = 1'b1;
      for (int i = 0; i < 20; i++) add_cycle(1'b0, rbit(), 18'($urandom), rbit(), CtrlNone, '0, 1'b0);
      add_cycle(1'b1, rbit(), 18'($urandom), rbit(), CtrlNone, '0, 1'b0);
      model_reset();
      add_cycle(1'b0, 1'b1, 18'($urandom), 1'b0, CtrlNone, '0, 1'b0);
    end
  endtask

  initial begin
    logic [5:0] op, a, b;
    int         cat, d;
    bit         ab;
    tests_run = 0;
    tests_failed = 0;
    rst = 1'b1; run = 1'b0; exec_done = 1'b0; mem_word = '0;
    model_reset();

    // After reset: idle with run low, then start.
    idle_then_run(2);

    // Directed cases.
    gen_instr({6'h01, 6'd2, 6'd3}, 5, 1'b0);
    gen_instr({6'h00, 6'd9, 6'd33}, 1, 1'b0);
    gen_instr({6'h00, 6'd0, 6'd0}, 1, 1'b0);
    gen_instr({6'h02, 6'd1, 6'd4}, 6, 1'b1);
    gen_instr({6'h04, 6'd7, 6'd1}, 2, 1'b0);
    gen_instr({6'h05, 6'd4, 6'd4}, 1, 1'b0);
    gen_instr({6'h3F, 6'd0, 6'd0}, 1, 1'b0);
    gen_instr({6'h2A, 6'd1, 6'd1}, 1, 1'b0);

    // Random instruction mix.
    for (int n = 0; n < 60; n++) begin
      cat = $urandom_range(0, 9);
      a = 6'($urandom_range(0, 4));
      b = 6'($urandom_range(0, 4));
      if (cat <= 5) op = 6'($urandom_range(1, 5));
      else if (cat == 6) begin
        op = 6'($urandom_range(1, 5));
        a = 6'($urandom_range(0, 63));
        b = 6'($urandom_range(0, 63));
      end else if (cat == 7) op = 6'h00;
      else if (cat == 8) op = 6'h3F;
      else op = 6'($urandom_range(6, 62));
      d = $urandom_range(1, 6);
      ab = (d >= 4) && ($urandom_range(0, 7) == 0);
      gen_instr({op, a, b}, d, ab);
    end

`ifdef FETCH_EXEC_TIMEOUT_EN
    gen_instr({6'h01, 6'd0, 6'd0}, 0, 1'b0);
`endif

    repeat (2) @(posedge clk);
    for (int i = 0; i < trace.size(); i++) begin
      #1;
      check_eq($sformatf("ctrl@%0d", i),
               {25'd0, PCOutEn, MARin, EN, RW, MDR_tobusin, IRin, PCinc}, {25'd0, trace[i].ctrl});
      check_eq($sformatf("bus_excl@%0d", i), {31'd0, PCOutEn & MDR_tobusin}, 32'd0);
      check_eq($sformatf("exec_start@%0d", i), {27'd0, exec_start}, {27'd0, trace[i].start});
      check_eq($sformatf("donefetch@%0d", i), {31'd0, donefetch}, {31'd0, trace[i].dfetch});
      check_eq($sformatf("halted@%0d", i), {31'd0, halted}, {31'd0, trace[i].hlt});
      check_eq($sformatf("illegal@%0d", i), {31'd0, illegal}, {31'd0, trace[i].ill});
      check_eq($sformatf("parameter1@%0d", i), {26'd0, parameter1}, {26'd0, trace[i].p1});
      check_eq($sformatf("parameter2@%0d", i), {26'd0, parameter2}, {26'd0, trace[i].p2});
`ifdef FETCH_EXEC_TIMEOUT_EN
      check_eq($sformatf("timeout@%0d", i), {31'd0, timeout}, {31'd0, trace[i].to});
`endif
      if (tests_failed >= 40) break;
      rst       = trace[i].rst;
      run       = trace[i].run;
      mem_word  = trace[i].word;
      exec_done = trace[i].done;
      @(posedge clk);
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
